// File: rtl/cp0_unit_if.sv
// CP0 bus between the M stage and coprocessor 0: mfc0/mtc0 access, exception
// reporting and the flush/redirect controls returned to the pipeline.
interface cp0_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] M_pc;
  logic        M_BD;
  logic [4:0]  M_ExcCode;
  logic        M_eret;
  logic [5:0]  HWInt;
  logic [31:0] DOut;
  logic        IntReq;
  logic        EXLClr;
  logic [31:0] EPC;

  modport master (
    output A1, A2, DIn, WE, M_pc, M_BD, M_ExcCode, M_eret, HWInt,
    input  DOut, IntReq, EXLClr, EPC
  );

  modport slave (
    input  A1, A2, DIn, WE, M_pc, M_BD, M_ExcCode, M_eret, HWInt,
    output DOut, IntReq, EXLClr, EPC
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers, interrupt and exception
// arbitration, and the IntReq/EXLClr flush controls for the pipeline.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h2021_1129
) (
  input  logic       clk,
  input  logic       reset,
  cp0_unit_if.slave  bus
);
  localparam int unsigned DW        = 32;
  localparam logic [4:0]  ADDR_SR   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE = 5'd13;
  localparam logic [4:0]  ADDR_EPC  = 5'd14;
  localparam logic [4:0]  ADDR_PRID = 5'd15;
  localparam logic [DW-1:0] SR_WMASK   = 32'h0000_FC01;
  localparam logic [DW-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // EXL doubles as the handler state
  typedef enum logic {ST_NORMAL = 1'b0, ST_IN_HANDLER = 1'b1} state_t;

  state_t        r_state;
  logic [DW-1:0] r_sr;       // IM and IE only; EXL lives in r_state
  logic          r_bd;
  logic [5:0]    r_ip;
  logic [4:0]    r_exccode;
  logic [DW-1:0] r_epc;

  logic          w_exl;
  logic          w_int;
  logic          w_exc;
  logic          w_intreq;
  logic          w_exlclr;
  logic [DW-1:0] w_pc_al;
  logic [DW-1:0] w_epc_cap;
  logic [DW-1:0] w_sr_rd;
  logic [DW-1:0] w_cause_rd;

  assign w_exl     = (r_state == ST_IN_HANDLER);
  assign w_int     = (|(bus.HWInt & r_sr[15:10])) & r_sr[0] & ~w_exl;
  assign w_exc     = (bus.M_ExcCode != 5'd0) & ~w_exl;
  assign w_intreq  = w_int | w_exc;
  assign w_exlclr  = bus.M_eret & ~w_intreq;
  assign w_pc_al   = bus.M_pc & ALIGN_MASK;
  assign w_epc_cap = bus.M_BD ? (w_pc_al - DW'(4)) : w_pc_al;

  assign w_sr_rd    = r_sr | {30'd0, w_exl, 1'b0};
  assign w_cause_rd = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'b00};

  assign bus.IntReq = w_intreq;
  assign bus.EXLClr = w_exlclr;
  assign bus.EPC    = r_epc;

  // Read port sees pre-edge state; no write bypass
  always_comb begin
    bus.DOut = '0;
    case (bus.A1)
      ADDR_SR:    bus.DOut = w_sr_rd;
      ADDR_CAUSE: bus.DOut = w_cause_rd;
      ADDR_EPC:   bus.DOut = r_epc;
      ADDR_PRID:  bus.DOut = PRID;
      default:    bus.DOut = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_NORMAL;
      r_sr      <= '0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= bus.HWInt;
      if (w_intreq) begin
        // Flushed instruction: any concurrent mtc0 is dropped
        r_state   <= ST_IN_HANDLER;
        r_bd      <= bus.M_BD;
        r_exccode <= w_int ? 5'd0 : bus.M_ExcCode;
        r_epc     <= w_epc_cap;
      end else begin
        if (bus.WE && (bus.A2 == ADDR_SR)) begin
          r_sr    <= bus.DIn & SR_WMASK;
          r_state <= bus.DIn[1] ? ST_IN_HANDLER : ST_NORMAL;
        end
        if (bus.WE && (bus.A2 == ADDR_EPC)) begin
          r_epc <= bus.DIn & ALIGN_MASK;
        end
        // eret overrides an mtc0 to EXL in the same cycle
        if (w_exlclr) begin
          r_state <= ST_NORMAL;
        end
      end
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: expectations are queued as stimulus is
// applied and retired against DUT outputs sampled between clock edges.
module tb_cp0_unit;
  localparam logic [31:0] PRID_V = 32'h2021_1129;

  logic clk;
  logic reset;

  cp0_unit_if bus ();

  cp0_unit #(.PRID(PRID_V)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  string       q_tag[$];
  logic [31:0] q_exp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (q_exp.size() == 0) begin
      chk("sb_underflow", 32'(q_exp.size()), 32'd1);
    end else begin
      chk(q_tag.pop_front(), obs, q_exp.pop_front());
    end
  endtask

  // mfc0 read through A1
  task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
    bus.A1 = addr;
    sb_push(tag, exp);
    #1;
    sb_pop(bus.DOut);
  endtask

  // 0: IntReq, 1: EXLClr, 2: EPC output
  task automatic cmb(input int which, input string tag, input logic [31:0] exp);
    sb_push(tag, exp);
    #1;
    case (which)
      0:       sb_pop(32'(bus.IntReq));
      1:       sb_pop(32'(bus.EXLClr));
      default: sb_pop(bus.EPC);
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.WE  = 1'b1;
    bus.A2  = addr;
    bus.DIn = data;
    step();
    bus.WE  = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    bus.A1        = 5'd0;
    bus.A2        = 5'd0;
    bus.DIn       = 32'd0;
    bus.WE        = 1'b0;
    bus.M_pc      = 32'd0;
    bus.M_BD      = 1'b0;
    bus.M_ExcCode = 5'd0;
    bus.M_eret    = 1'b0;
    bus.HWInt     = 6'd0;
    #25;

    // Reset state
    rd(5'd12, "rst_sr", 32'd0);
    rd(5'd13, "rst_cause", 32'd0);
    rd(5'd14, "rst_epc", 32'd0);
    rd(5'd15, "rst_prid", PRID_V);
    cmb(0, "rst_intreq", 32'd0);
    bus.M_ExcCode = 5'd12;
    cmb(0, "rst_exc_intreq", 32'd1);
    bus.M_ExcCode = 5'd0;
    @(negedge clk);
    reset = 1'b1;
    step();

    // Enabled interrupt
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, "sr_written", 32'h0000_0401);
    bus.HWInt = 6'b000001;
    bus.M_pc  = 32'h0000_3010;
    cmb(0, "int_intreq", 32'd1);
    step();
    rd(5'd12, "int_sr_exl", 32'h0000_0403);
    rd(5'd13, "int_cause", 32'h0000_0400);
    rd(5'd14, "int_epc_rd", 32'h0000_3010);
    cmb(2, "int_epc_out", 32'h0000_3010);
    cmb(0, "int_intreq_drop", 32'd0);

    // eret with interrupt held
    bus.M_eret = 1'b1;
    cmb(1, "eret_exlclr", 32'd1);
    cmb(0, "eret_intreq", 32'd0);
    step();
    bus.M_eret = 1'b0;
    rd(5'd12, "eret_sr", 32'h0000_0401);
    cmb(0, "int_refire", 32'd1);
    bus.HWInt = 6'd0;
    cmb(0, "int_released", 32'd0);

    // Exception in a delay slot
    bus.M_ExcCode = 5'd4;
    bus.M_pc      = 32'h0000_3024;
    bus.M_BD      = 1'b1;
    cmb(0, "bd_intreq", 32'd1);
    step();
    bus.M_ExcCode = 5'd0;
    bus.M_BD      = 1'b0;
    rd(5'd14, "bd_epc", 32'h0000_3020);
    rd(5'd13, "bd_cause", 32'h8000_0010);
    rd(5'd12, "bd_sr", 32'h0000_0403);
    bus.M_ExcCode = 5'd4;
    cmb(0, "exc_masked_exl", 32'd0);
    bus.M_ExcCode = 5'd0;

    // eret concurrent with mtc0 SR setting EXL: eret wins for EXL
    bus.M_eret = 1'b1;
    bus.WE     = 1'b1;
    bus.A2     = 5'd12;
    bus.DIn    = 32'h0000_0803;
    cmb(1, "eret_mtc0_exlclr", 32'd1);
    step();
    bus.M_eret = 1'b0;
    bus.WE     = 1'b0;
    rd(5'd12, "eret_mtc0_sr", 32'h0000_0801);
    bus.HWInt = 6'b000001;
    cmb(0, "im_masked", 32'd0);
    bus.HWInt = 6'b000010;
    cmb(0, "im_enabled", 32'd1);
    bus.HWInt = 6'd0;
    mtc0(5'd12, 32'h0000_0401);

    // Interrupt beats exception; concurrent mtc0 EPC dropped
    bus.HWInt     = 6'b000001;
    bus.M_ExcCode = 5'd10;
    bus.M_pc      = 32'h0000_4002;
    bus.WE        = 1'b1;
    bus.A2        = 5'd14;
    bus.DIn       = 32'h0000_5000;
    bus.M_eret    = 1'b1;
    cmb(0, "prio_intreq", 32'd1);
    cmb(1, "prio_exlclr", 32'd0);
    step();
    bus.HWInt     = 6'd0;
    bus.M_ExcCode = 5'd0;
    bus.WE        = 1'b0;
    bus.M_eret    = 1'b0;
    rd(5'd14, "prio_epc", 32'h0000_4000);
    rd(5'd13, "prio_cause", 32'h0000_0400);
    rd(5'd12, "prio_sr", 32'h0000_0403);

    // mtc0 EPC alignment inside the handler
    mtc0(5'd14, 32'h0000_3013);
    cmb(2, "mtc0_epc_out", 32'h0000_3010);
    rd(5'd14, "mtc0_epc_rd", 32'h0000_3010);

    // Asynchronous reset mid-handler, no clock edge
    #3;
    reset = 1'b0;
    #1;
    rd(5'd12, "arst_sr", 32'd0);
    rd(5'd13, "arst_cause", 32'd0);
    rd(5'd14, "arst_epc", 32'd0);
    cmb(2, "arst_epc_out", 32'd0);
    reset = 1'b1;
    step();
    cmb(0, "arst_intreq", 32'd0);
    rd(5'd15, "prid_again", PRID_V);
    rd(5'd3, "unmapped_rd", 32'd0);

    // Cause is read-only
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, "cause_ro", 32'd0);
    rd(5'd12, "cause_ro_sr", 32'd0);

    chk("sb_drain", 32'(q_exp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 for the five-stage MIPS pipeline: holds SR, Cause, EPC and PRId and arbitrates interrupts and exceptions. It is the producer end of the flush controls that the decode/execute pipeline register consumes. It sits beside the M stage. It raises `IntReq` to redirect fetch to 0x4180 and to flush younger stages, and raises `EXLClr` when an `eret` commits. It also supplies `EPC` to the PC-select logic.

## Interface
- PRID, default 32'h2021_1129: constant value returned for register 15.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Low clears all registers immediately.
- A1  in  5  CP0 read address (mfc0 rd field).
- A2  in  5  CP0 write address (mtc0 rd field).
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 commit in M stage.
- M_pc  in  32  PC of the instruction currently in M.
- M_BD  in  1  M instruction is in a branch delay slot.
- M_ExcCode  in  5  exception code of the M instruction. 0 means none.
- M_eret  in  1  eret in M stage.
- HWInt  in  6  hardware interrupt lines, level-sensitive.
- DOut  out  32  combinational read data for A1.
- IntReq  out  1  combinational: take interrupt/exception this cycle.
- EXLClr  out  1  combinational: eret commits this cycle.
- EPC  out  32  current EPC register value.

## Operation
- SR (12): IM = bits 15:10, EXL = bit 1, IE = bit 0. Other bits read as 0.
- Cause (13): BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2. Other bits read as 0. Cause is read-only to mtc0.
- EPC (14): word-aligned; bits 1:0 are always 0.
- PRId (15): returns PRID. Any other address reads 0.
- Handler state is carried by EXL. EXL=0 is NORMAL; EXL=1 is IN_HANDLER.
- Interrupt condition: int = |(HWInt & IM) & IE & ~EXL.
- Exception condition: exc = (M_ExcCode != 0) & ~EXL. Exceptions are not masked by IE.
- IntReq = int | exc.
- Priority: an interrupt beats a simultaneous exception.
- Recorded code: ExcCode 0 for an interrupt, otherwise M_ExcCode.
- On an edge with IntReq=1:
  - EXL <= 1, moving NORMAL to IN_HANDLER.
  - Cause.BD <= M_BD.
  - Cause.ExcCode <= the recorded code.
  - EPC <= M_BD ? {M_pc[31:2],2'b00} - 4 : {M_pc[31:2],2'b00}.
- EXLClr = M_eret & ~IntReq. On an edge with EXLClr=1, EXL <= 0, moving IN_HANDLER to NORMAL.
- Cause.IP <= HWInt on every edge, regardless of masking.
- mtc0 applies on an edge with WE=1 and IntReq=0:
  - A2=12 writes IM, EXL and IE from DIn.
  - A2=14 writes EPC <= {DIn[31:2],2'b00}.
  - Any other A2 is ignored.
- A write is dropped when IntReq=1 in the same cycle, because the instruction is flushed.
- Simultaneous mtc0 SR with EXLClr: EXLClr wins for EXL. IM and IE take the mtc0 data.
- DOut reflects register state before the current edge. There is no write-to-read bypass.

## Timing
- Reset (reset=0, asynchronous): SR=0, Cause=0, EPC=0.
- Outputs after reset:
  - IntReq = (M_ExcCode != 0), since IE=0 and EXL=0.
  - EXLClr = M_eret.
  - DOut = 0 for addresses 12–14 and PRID for address 15.
- Reset deasserted mid-handler returns the block to NORMAL with EXL=0.
- IntReq and EXLClr are combinational in the same cycle as their inputs. Their register effects are visible in the next cycle.
- IntReq drops the cycle after it is taken, because EXL is then 1.
- A held HWInt re-fires only after an eret has cleared EXL, and only while IE and IM still permit it.
- EPC is valid at the output one cycle after the capture edge.
- An eret in M reads the EPC value as of the previous edge.

## Test plan
- Reset low with M_ExcCode=0 -> SR, Cause and EPC read 0, PRId reads PRID, IntReq=0. Then M_ExcCode=12 -> IntReq=1 immediately.
- mtc0 SR=0x0000_0401 (IM[10], IE), then HWInt=6'b000001, M_pc=0x3010, M_BD=0 -> IntReq=1. Next cycle: EXL=1, ExcCode=0, EPC=0x3010, IntReq=0.
- Exception in delay slot: M_ExcCode=4, M_pc=0x3024, M_BD=1 -> EPC=0x3020, Cause.BD=1, Cause.ExcCode=4. Cause reads 0x8000_0010.
- Simultaneous HWInt (enabled) and M_ExcCode=10 -> ExcCode=0. Concurrent mtc0 EPC=0x5000 is dropped; EPC equals the PC-derived value.
- In handler (EXL=1) with HWInt held -> IntReq stays 0. M_eret=1 -> EXLClr=1, EXL=0 next cycle, and IntReq reasserts the following cycle.
- Reset pulsed while EXL=1 and EPC=0x3010 -> SR, Cause and EPC clear asynchronously, before the next clk edge.
